// File: rtl/medida_serial_rx.sv
// medida_serial_rx: receiving end of the measurement serial link.
// Takes UART characters (1 start, 7 data LSB first, even parity, 2 stop bits)
// and parses frames of three ASCII digits followed by '#' into 12-bit BCD.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   entrada_serial asynchronous serial line, idles high
//   medida         last good frame: [11:8] hundreds, [7:4] tens, [3:0] units
//   pronto         one-cycle pulse when medida is updated
//   erro           one-cycle pulse on a character or frame error
//   db_estado      receiver state code for debug display
module medida_serial_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [3:0] {
    OCIOSO   = 4'h0,
    INICIO   = 4'h1,
    DADOS    = 4'h2,
    PARIDADE = 4'h3,
    PARADA   = 4'h4,
    CHAR     = 4'h5,
    ESPERA   = 4'h6,
    ERRO_RX  = 4'hE
  } estado_t;

  estado_t          estado;
  logic             sync_a, sync_b;
  logic [CNT_W-1:0] cnt_clk;
  logic [2:0]       cnt_bit;
  logic [6:0]       dado;
  logic             paridade;
  logic [1:0]       posicao;
  logic [3:0]       centena, dezena, unidade;
  logic             eh_digito;

  // Synchroniser resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= entrada_serial;
      sync_b <= sync_a;
    end
  end

  always_comb begin
    eh_digito = (dado >= 7'h30) && (dado <= 7'h39);
  end

  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      cnt_clk  <= '0;
      cnt_bit  <= '0;
      dado     <= '0;
      paridade <= 1'b0;
      posicao  <= '0;
      centena  <= '0;
      dezena   <= '0;
      unidade  <= '0;
      medida   <= '0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        OCIOSO: begin
          cnt_clk <= '0;
          cnt_bit <= '0;
          if (!sync_b) estado <= INICIO;
        end
        INICIO: begin
          if (cnt_clk == CNT_HALF) begin
            cnt_clk <= '0;
            cnt_bit <= '0;
            estado  <= sync_b ? OCIOSO : DADOS;
          end else begin
            cnt_clk <= cnt_clk + 1'b1;
          end
        end
        DADOS: begin
          if (cnt_clk == CNT_BIT) begin
            cnt_clk <= '0;
            dado    <= {sync_b, dado[6:1]};
            cnt_bit <= cnt_bit + 1'b1;
            if (cnt_bit == 3'd6) estado <= PARIDADE;
          end else begin
            cnt_clk <= cnt_clk + 1'b1;
          end
        end
        PARIDADE: begin
          if (cnt_clk == CNT_BIT) begin
            cnt_clk  <= '0;
            paridade <= sync_b;
            estado   <= PARADA;
          end else begin
            cnt_clk <= cnt_clk + 1'b1;
          end
        end
        PARADA: begin
          if (cnt_clk == CNT_BIT) begin
            cnt_clk <= '0;
            // framing error or odd overall parity
            if (!sync_b || ((^dado) ^ paridade)) estado <= ERRO_RX;
            else                                  estado <= CHAR;
          end else begin
            cnt_clk <= cnt_clk + 1'b1;
          end
        end
        CHAR: begin
          estado <= ESPERA;
          if (posicao == 2'd3) begin
            posicao <= '0;
            if (dado == 7'h23) begin
              medida <= {centena, dezena, unidade};
              pronto <= 1'b1;
            end else begin
              erro <= 1'b1;
            end
          end else if (eh_digito) begin
            case (posicao)
              2'd0:    centena <= dado[3:0];
              2'd1:    dezena  <= dado[3:0];
              default: unidade <= dado[3:0];
            endcase
            posicao <= posicao + 2'd1;
          end else begin
            erro    <= 1'b1;
            posicao <= '0;
          end
        end
        ERRO_RX: begin
          erro    <= 1'b1;
          posicao <= '0;
          estado  <= ESPERA;
        end
        ESPERA: begin
          if (sync_b) estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_medida_serial_rx.sv
// tb_medida_serial_rx: drives UART characters into medida_serial_rx and
// compares the stream of pronto/erro pulses and medida values against a
// frame-level reference model.
module tb_medida_serial_rx;

  localparam int unsigned CPB = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        entrada_serial = 1'b1;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  medida_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .medida         (medida),
    .pronto         (pronto),
    .erro           (erro),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        is_err;
    logic [11:0] val;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_q[$];

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;
  int hold_viol = 0;
  logic [11:0] prev_medida = '0;

  // reference model state
  int          mdl_pos = 0;
  int          mdl_dig[3];
  logic [11:0] mdl_medida = '0;

  // output monitor
  always @(negedge clock) begin
    if (reset) begin
      prev_medida = medida;
    end else begin
      if (pronto && erro) both_cnt++;
      if (pronto) got_q.push_back('{is_err: 1'b0, val: medida});
      if (erro)   got_q.push_back('{is_err: 1'b1, val: 12'h000});
      if (medida !== prev_medida && !pronto) hold_viol++;
      prev_medida = medida;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_char(input logic [6:0] c, input bit flip, input bit bad_stop);
    int v;
    v = int'(c);
    if (flip || bad_stop) begin
      exp_q.push_back('{is_err: 1'b1, val: 12'h000});
      mdl_pos = 0;
    end else if (mdl_pos < 3) begin
      if (v >= 48 && v <= 57) begin
        mdl_dig[mdl_pos] = v - 48;
        mdl_pos++;
      end else begin
        exp_q.push_back('{is_err: 1'b1, val: 12'h000});
        mdl_pos = 0;
      end
    end else begin
      if (v == 35) begin
        mdl_medida = 12'(mdl_dig[0] * 256 + mdl_dig[1] * 16 + mdl_dig[2]);
        exp_q.push_back('{is_err: 1'b0, val: mdl_medida});
      end else begin
        exp_q.push_back('{is_err: 1'b1, val: 12'h000});
      end
      mdl_pos = 0;
    end
  endtask

  task automatic drive_bit(input logic b);
    entrada_serial = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_char(input logic [6:0] c, input bit flip, input bit bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(c[i]);
    drive_bit((^c) ^ flip);
    drive_bit(!bad_stop);
    drive_bit(1'b1);
    model_char(c, flip, bad_stop);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(7'(s[i]), 1'b0, 1'b0);
  endtask

  task automatic check_phase(input string tag);
    int n;
    repeat (20) @(negedge clock);
    chk({tag, "/count"}, 16'(got_q.size()), 16'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s/ev%0d", tag, i), 16'(got_q[i]), 16'(exp_q[i]));
    chk({tag, "/db_estado"}, 16'(db_estado), 16'h0);
    chk({tag, "/medida"}, 16'(medida), 16'(mdl_medida));
    chk({tag, "/pronto_erro_overlap"}, 16'(both_cnt), 16'h0);
    chk({tag, "/medida_hold"}, 16'(hold_viol), 16'h0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          kind, n, p;
    logic [6:0]  fr[4];
    logic [6:0]  ch;

    // reset state
    repeat (4) @(negedge clock);
    chk("reset/medida", 16'(medida), 16'h0);
    chk("reset/pronto", 16'(pronto), 16'h0);
    chk("reset/erro", 16'(erro), 16'h0);
    chk("reset/db_estado", 16'(db_estado), 16'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    send_str("123#");
    check_phase("f123");

    send_str("045#");
    send_str("990#");
    check_phase("b2b");

    send_str("1A3#");
    check_phase("bad_digit");
    send_str("777#");
    check_phase("f777");

    send_char(7'h35, 1'b1, 1'b0);
    send_str("12#");
    check_phase("parity");

    // short low glitch on an idle line
    entrada_serial = 1'b0;
    repeat (3) @(negedge clock);
    entrada_serial = 1'b1;
    check_phase("glitch");

    send_char(7'h37, 1'b0, 1'b1);
    check_phase("stop0");

    // reset during the tens digit of "456#"
    send_char(7'h34, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("midrst/medida", 16'(medida), 16'h0);
    chk("midrst/pronto", 16'(pronto), 16'h0);
    chk("midrst/erro", 16'(erro), 16'h0);
    chk("midrst/db_estado", 16'(db_estado), 16'h0);
    chk("midrst/events", 16'(got_q.size()), 16'h0);
    got_q.delete();
    exp_q.delete();
    mdl_pos = 0;
    mdl_medida = '0;
    repeat (20) @(negedge clock);
    send_str("321#");
    check_phase("after_rst");

    // randomized frames with occasional corruption
    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(0, 9);
      n = (kind == 9) ? 3 : 4;
      for (int k = 0; k < n - 1; k++) fr[k] = 7'(48 + $urandom_range(0, 9));
      fr[n-1] = 7'h23;
      p = $urandom_range(0, n - 1);
      for (int k = 0; k < n; k++) begin
        ch = (kind == 6 && k == p) ? 7'($urandom_range(32, 63)) : fr[k];
        send_char(ch, (kind == 7 && k == p), (kind == 8 && k == p));
      end
    end
    check_phase("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
